// File: rtl/rram_readout.sv
// Read-back sequencer for the RRAM array: sweeps each row, samples the sense amps and scores
// every row against a captured query, streaming records and tracking the best-matching row.
module rram_readout #(
  parameter int N_ROWS  = 12,
  parameter int N_COLS  = 12,
  parameter int SETTLE  = 4,
  parameter int ROW_W   = 4,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_COLS-1:0]  query,
  input  logic [N_COLS-1:0]  sense,
  output logic               rd_en,
  output logic [N_ROWS-1:0]  rd_wl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_row,
  output logic [N_COLS-1:0]  out_data,
  output logic [SCORE_W-1:0] out_score,
  output logic [ROW_W-1:0]   best_label,
  output logic [SCORE_W-1:0] best_score,
  output logic               done,
  output logic               busy
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, STREAM, DONE} state_t;

  state_t             state, next_state;
  logic [ROW_W-1:0]   row;
  logic [CNT_W-1:0]   settle_cnt;
  logic [N_COLS-1:0]  q_reg;
  logic [SCORE_W-1:0] match_score;
  logic               last_settle, last_row;

  assign last_settle = (settle_cnt == CNT_W'(SETTLE - 1));
  assign last_row    = (row == ROW_W'(N_ROWS - 1));

  function automatic logic [SCORE_W-1:0] popcount(input logic [N_COLS-1:0] v);
    logic [SCORE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_COLS; i++) cnt = cnt + SCORE_W'(v[i]);
    return cnt;
  endfunction

  assign match_score = popcount(~(sense ^ q_reg));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Control outputs are decoded from state so a reset drops them without waiting for a clock.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = DRIVE;
      end
      DRIVE: begin
        rd_en = 1'b1;
        if (last_settle) next_state = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) next_state = last_row ? DONE : DRIVE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_wl = '0;
    for (int i = 0; i < N_ROWS; i++) rd_wl[i] = rd_en && (row == ROW_W'(i));
  end

  // Row 0 always seeds the best; later rows replace it only on a strictly higher score.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= '0;
      settle_cnt <= '0;
      q_reg      <= '0;
      out_row    <= '0;
      out_data   <= '0;
      out_score  <= '0;
      best_label <= '0;
      best_score <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_reg      <= query;
            row        <= '0;
            settle_cnt <= '0;
          end
        end
        DRIVE: begin
          if (last_settle) begin
            settle_cnt <= '0;
            out_data   <= sense;
            out_score  <= match_score;
            out_row    <= row;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_row == '0 || out_score > best_score) begin
              best_label <= out_row;
              best_score <= out_score;
            end
            if (!last_row) row <= row + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rram_readout.sv
// Self-checking bench for rram_readout: table-driven sweeps plus random sweeps scored by a
// behavioural model, reset-abort and SETTLE=1 builds.
module tb_rram_readout;

  localparam int NR = 12;
  localparam int NC = 12;
  localparam int ST = 4;
  localparam int SWEEP = NR * (ST + 1) + 1;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [NC-1:0] query, sense;
  logic          rd_en, out_valid, done, busy;
  logic [NR-1:0] rd_wl;
  logic [3:0]    out_row, out_score, best_label, best_score;
  logic [NC-1:0] out_data;

  logic          start1, rd_en1, out_valid1, done1, busy1;
  logic [NC-1:0] sense1, out_data1;
  logic [NR-1:0] rd_wl1;
  logic [3:0]    out_row1, out_score1, best_label1, best_score1;

  logic [NC-1:0] mem [NR];

  int checks = 0;
  int errors = 0;

  int            rec_row[$];
  logic [NC-1:0] rec_data[$];
  int            rec_score[$];

  always #5 clk = ~clk;

  rram_readout #(.N_ROWS(NR), .N_COLS(NC), .SETTLE(ST), .ROW_W(4), .SCORE_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .query(query), .sense(sense),
    .rd_en(rd_en), .rd_wl(rd_wl), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .out_score(out_score),
    .best_label(best_label), .best_score(best_score), .done(done), .busy(busy));

  rram_readout #(.N_ROWS(NR), .N_COLS(NC), .SETTLE(1), .ROW_W(4), .SCORE_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .query(query), .sense(sense1),
    .rd_en(rd_en1), .rd_wl(rd_wl1), .out_valid(out_valid1), .out_ready(1'b1),
    .out_row(out_row1), .out_data(out_data1), .out_score(out_score1),
    .best_label(best_label1), .best_score(best_score1), .done(done1), .busy(busy1));

  // Behavioural array: whichever wordline is raised returns that row's stored bits.
  always_comb begin
    sense  = '0;
    sense1 = '0;
    for (int i = 0; i < NR; i++) begin
      if (rd_wl[i])  sense  = sense  | mem[i];
      if (rd_wl1[i]) sense1 = sense1 | mem[i];
    end
  end

  typedef struct {
    string         name;
    int            kind;
    logic [NC-1:0] q;
    int            stall_row;
    int            stall_len;
    bit            rand_ready;
    bit            busy_start;
    int            exp_label;
    int            exp_score;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int modelScore(input logic [NC-1:0] d, input logic [NC-1:0] q);
    logic [NC-1:0] m;
    m = ~(d ^ q);
    return $countones(m);
  endfunction

  task automatic modelBest(input logic [NC-1:0] q, output int label, output int score);
    label = 0;
    score = modelScore(mem[0], q);
    for (int r = 1; r < NR; r++) begin
      if (modelScore(mem[r], q) > score) begin
        label = r;
        score = modelScore(mem[r], q);
      end
    end
  endtask

  task automatic fillMem(input int kind, input logic [NC-1:0] q);
    for (int r = 0; r < NR; r++) begin
      case (kind)
        0:       mem[r] = (r == 7) ? q : 12'hFFF;
        1:       mem[r] = q;
        2:       mem[r] = ~q;
        default: mem[r] = NC'($urandom);
      endcase
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [NC-1:0] q, held_data;
    int cycles, stalls, stalled, m_label, m_score, held_row, held_score;
    bit got_done, prev_stall;
    q = (v.kind == 3) ? NC'($urandom) : v.q;
    fillMem(v.kind, q);
    rec_row.delete(); rec_data.delete(); rec_score.delete();
    @(posedge clk); #1;
    start = 1'b1; query = q; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; query = NC'($urandom);
    cycles = 0; stalls = 0; stalled = 0; got_done = 0; prev_stall = 0;
    held_row = 0; held_score = 0; held_data = '0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (out_valid && int'(out_row) == v.stall_row && stalled < v.stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else if (v.rand_ready) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready = 1'b1;
      end
      if (v.busy_start && c >= 20) begin
        start = 1'b1;
        query = NC'($urandom);
      end
      @(negedge clk);
      if (busy) cycles++;
      checkOutput("wl_onehot", 32'($countones(rd_wl) <= 1), 1);
      checkOutput("wl_needs_en", 32'((rd_wl == '0) || rd_en), 1);
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(out_valid), 1);
        checkOutput("stall_row", 32'(out_row), held_row);
        checkOutput("stall_data", 32'(out_data), 32'(held_data));
        checkOutput("stall_score", 32'(out_score), held_score);
        checkOutput("stall_wl", 32'(rd_wl), 0);
      end
      prev_stall = out_valid && !out_ready;
      held_row = out_row; held_data = out_data; held_score = out_score;
      if (out_valid && !out_ready) stalls++;
      if (out_valid && out_ready) begin
        rec_row.push_back(out_row);
        rec_data.push_back(out_data);
        rec_score.push_back(out_score);
      end
      if (done) got_done = 1;
    end
    if (!got_done) checkOutput({v.name, "_done_timeout"}, 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput({v.name, "_done_pulse"}, 32'(done), 0);
    checkOutput({v.name, "_idle_busy"}, 32'(busy), 0);
    checkOutput({v.name, "_cycles"}, cycles, (v.exp_cycles >= 0) ? v.exp_cycles : SWEEP + stalls);
    checkOutput({v.name, "_records"}, rec_row.size(), NR);
    for (int i = 0; i < rec_row.size(); i++) begin
      checkOutput({v.name, "_rec_row"}, rec_row[i], i);
      if (i < NR) begin
        checkOutput({v.name, "_rec_data"}, 32'(rec_data[i]), 32'(mem[i]));
        checkOutput({v.name, "_rec_score"}, rec_score[i], modelScore(mem[i], q));
      end
    end
    modelBest(q, m_label, m_score);
    checkOutput({v.name, "_best_label"}, 32'(best_label), m_label);
    checkOutput({v.name, "_best_score"}, 32'(best_score), m_score);
    if (v.exp_label >= 0) begin
      checkOutput({v.name, "_tbl_label"}, 32'(best_label), v.exp_label);
      checkOutput({v.name, "_tbl_score"}, 32'(best_score), v.exp_score);
    end
  endtask

  task automatic midSweepReset();
    bit seen;
    fillMem(0, 12'hA5A);
    @(posedge clk); #1;
    start = 1'b1; query = 12'hA5A; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (rd_wl[5]) seen = 1;
    end
    checkOutput("rst_reach_row5", 32'(seen), 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_rd_en", 32'(rd_en), 0);
    checkOutput("rst_rd_wl", 32'(rd_wl), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_valid", 32'(out_valid), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_no_done", 32'(done), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_best_label", 32'(best_label), 0);
    checkOutput("rst_best_score", 32'(best_score), 0);
    checkOutput("rst_stays_idle", 32'(busy), 0);
  endtask

  task automatic settleOneSweep();
    logic [NC-1:0] q;
    int cycles, recs, m_label, m_score;
    int wl_cnt[NR];
    bit got_done;
    q = NC'($urandom);
    fillMem(3, q);
    for (int i = 0; i < NR; i++) wl_cnt[i] = 0;
    @(posedge clk); #1;
    start1 = 1'b1; query = q;
    @(posedge clk); #1;
    start1 = 1'b0;
    cycles = 0; recs = 0; got_done = 0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(negedge clk);
      if (busy1) cycles++;
      if (out_valid1) recs++;
      for (int i = 0; i < NR; i++) wl_cnt[i] += int'(rd_wl1[i]);
      checkOutput("s1_wl_onehot", 32'($countones(rd_wl1) <= 1), 1);
      checkOutput("s1_wl_needs_en", 32'((rd_wl1 == '0) || rd_en1), 1);
      if (done1) got_done = 1;
    end
    checkOutput("s1_done_seen", 32'(got_done), 1);
    checkOutput("s1_cycles", cycles, 25);
    checkOutput("s1_records", recs, NR);
    for (int i = 0; i < NR; i++) checkOutput("s1_wl_once", wl_cnt[i], 1);
    modelBest(q, m_label, m_score);
    checkOutput("s1_best_label", 32'(best_label1), m_label);
    checkOutput("s1_best_score", 32'(best_score1), m_score);
  endtask

  initial begin
    vecs[0] = '{"nominal",   0, 12'hA5A, -1, 0,  1'b0, 1'b0, 7, 12, SWEEP};
    vecs[1] = '{"backpress", 0, 12'hA5A, 3,  10, 1'b0, 1'b0, 7, 12, SWEEP + 10};
    vecs[2] = '{"tie_equal", 1, 12'h3C5, -1, 0,  1'b0, 1'b0, 0, 12, SWEEP};
    vecs[3] = '{"tie_inv",   2, 12'h3C5, -1, 0,  1'b0, 1'b0, 0, 0,  SWEEP};
    vecs[4] = '{"busy_start",0, 12'hA5A, -1, 0,  1'b0, 1'b1, 7, 12, SWEEP};
    vecs[5] = '{"random0",   3, 12'h000, -1, 0,  1'b1, 1'b0, -1, -1, -1};
    vecs[6] = '{"random1",   3, 12'h000, -1, 0,  1'b1, 1'b0, -1, -1, -1};
    vecs[7] = '{"random2",   3, 12'h000, 5,  4,  1'b1, 1'b1, -1, -1, -1};

    reset = 1'b0; start = 1'b0; start1 = 1'b0; out_ready = 1'b0; query = '0;
    for (int r = 0; r < NR; r++) mem[r] = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rd_en", 32'(rd_en), 0);
    checkOutput("reset_rd_wl", 32'(rd_wl), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_valid", 32'(out_valid), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_best", 32'({best_label, best_score}), 0);
    checkOutput("reset_record", 32'({out_row, out_data, out_score}), 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    midSweepReset();
    settleOneSweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
